// File: rtl/counter_down_timer.sv
// ----------------------------------------------------------------------------
// counter_down_timer
//   Loadable down-counter / timer. A start value is loaded, the counter
//   decrements on enabled cycles, and a one-cycle tc pulse marks the edge on
//   which the count reaches zero. In one-shot mode the block then parks in
//   DONE; in periodic mode it reloads the start value on the next enabled
//   edge, giving one tc pulse every (reload value + 1) enabled cycles.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   clr          asynchronous active-high reset
//   load         synchronous load strobe (wins over en)
//   load_val     start / reload value, unsigned
//   en           count enable
//   auto_reload  1 = periodic, 0 = one-shot; sampled every edge
//   counter      current count value (registered)
//   busy         high while in RUN (registered)
//   tc           terminal-count pulse, one cycle wide (registered)
//   done         high while in DONE (registered)
// ----------------------------------------------------------------------------
module counter_down_timer #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         auto_reload,
    output logic [N-1:0] counter,
    output logic         busy,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] reload_reg;

    // busy and done are written alongside state so they stay registered
    // copies of the state decode rather than combinational outputs.
    // NOTE: every register here uses non-blocking assignment so all updates
    // in this block see the pre-edge values of counter/state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            counter    <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            // tc is a pulse: only the 1 -> 0 decrement edge raises it.
            tc <= 1'b0;

            if (load) begin
                counter    <= load_val;
                reload_reg <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end else begin
                    // A zero load has nothing to count: finish without tc.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (state == RUN && en) begin
                if (counter > ONE) begin
                    counter <= counter - ONE;
                end else if (counter == ONE) begin
                    counter <= '0;
                    tc      <= 1'b1;
                    if (!auto_reload) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else if (auto_reload) begin
                    // Zero in RUN only happens in periodic mode: the extra
                    // enabled cycle spent at zero makes the period reload+1.
                    counter <= reload_reg;
                end else begin
                    // Periodic mode was abandoned while sitting at zero.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
            // IDLE, DONE, and RUN with en=0 hold everything except tc.
        end
    end

endmodule

// File: tb/tb_counter_down_timer.sv
// ----------------------------------------------------------------------------
// tb_counter_down_timer
//   Self-checking bench for counter_down_timer (N=3). Directed scenarios for
//   reset, one-shot, periodic with enable gating, load priority and the
//   boundary cases, then a randomized run. Every edge is compared against a
//   behavioural model that tracks "how many counts remain" with integers.
// ----------------------------------------------------------------------------
module tb_counter_down_timer;

    localparam int N   = 3;
    localparam int MAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         clr;
    logic         load;
    logic [N-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [N-1:0] counter;
    logic         busy;
    logic         tc;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 = idle, 1 = counting, 2 = finished.
    int m_cnt;
    int m_rel;
    int m_phase;
    int m_tc;
    int prev_tc;

    counter_down_timer #(.N(N)) dut (
        .clk        (clk),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .en         (en),
        .auto_reload(auto_reload),
        .counter    (counter),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt   = 0;
        m_rel   = 0;
        m_phase = 0;
        m_tc    = 0;
    endfunction

    // One rising edge of the reference behaviour, using the sampled inputs.
    function automatic void model_step();
        int was;
        if (clr) begin
            model_reset();
            return;
        end
        m_tc = 0;
        if (load) begin
            m_cnt   = int'(load_val);
            m_rel   = int'(load_val);
            m_phase = (m_cnt == 0) ? 2 : 1;
        end else if (m_phase == 1 && en) begin
            was = m_cnt;
            if (was == 0) begin
                if (auto_reload) m_cnt = m_rel;
                else             m_phase = 2;
            end else begin
                m_cnt = was - 1;
                if (m_cnt == 0) begin
                    m_tc = 1;
                    if (!auto_reload) m_phase = 2;
                end
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".counter"}, int'(counter), m_cnt);
        check({tag, ".busy"},    int'(busy),    int'(m_phase == 1));
        check({tag, ".done"},    int'(done),    int'(m_phase == 2));
        check({tag, ".tc"},      int'(tc),      m_tc);
        check({tag, ".tc_twice"}, int'(tc && prev_tc == 1), 0);
        check({tag, ".range"},   int'(int'(counter) <= MAX), 1);
        prev_tc = int'(tc);
    endtask

    // Advance one edge, update the model, sample 1 ns later and compare.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic set_in(input bit l, input int v, input bit e, input bit a);
        load        = l;
        load_val    = v[N-1:0];
        en          = e;
        auto_reload = a;
    endtask

    // Async clear between edges; outputs must drop before the next edge.
    task automatic clr_pulse(input string tag);
        clr = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".async_cnt"}, int'(counter), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seq_cnt[7];
        int seq_tc[7];
        bit seen;

        prev_tc = 0;
        clr = 1'b1;
        set_in(0, 0, 0, 0);
        #1;
        model_reset();
        compare_all("reset0");

        // Hold clr across two edges (20 ns), then release between edges.
        tick("reset_hold");
        tick("reset_hold");
        clr = 1'b0;

        // IDLE ignores en.
        set_in(0, 0, 1, 0);
        tick("idle_en");
        check("idle_en.cnt", int'(counter), 0);

        // Start a count, then abort it with a second clr pulse mid-run.
        set_in(1, 5, 1, 0);
        tick("pre_abort_load");
        set_in(0, 0, 1, 0);
        tick("pre_abort_run");
        check("pre_abort.cnt", int'(counter), 4);
        clr_pulse("abort");
        tick("abort_hold");
        tick("abort_hold");
        clr = 1'b0;

        // One-shot from 5.
        set_in(1, 5, 1, 0);
        tick("os_load");
        check("os_load.cnt", int'(counter), 5);
        set_in(0, 0, 1, 0);
        for (int i = 4; i >= 0; i--) begin
            tick("os_run");
            check("os_seq", int'(counter), i);
            check("os_tc", int'(tc), int'(i == 0));
        end
        check("os_done", int'(done), 1);
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, i[0], i[1]);
            tick("os_park");
            check("os_park.cnt", int'(counter), 0);
        end

        // Periodic from 3: 3,2,1,0,3,2,1,0 with tc every fourth cycle.
        set_in(1, 3, 1, 1);
        tick("per_load");
        seq_cnt = '{2, 1, 0, 3, 2, 1, 0};
        seq_tc  = '{0, 0, 1, 0, 0, 0, 1};
        set_in(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) begin
            tick("per_run");
            check("per_seq", int'(counter), seq_cnt[i]);
            check("per_tc", int'(tc), seq_tc[i]);
        end
        // Gate en for two cycles: the next pulse arrives 6 cycles later.
        tick("gate_reload");
        set_in(0, 0, 0, 1);
        tick("gate_hold");
        check("gate_hold.cnt", int'(counter), 3);
        tick("gate_hold");
        check("gate_hold.cnt", int'(counter), 3);
        set_in(0, 0, 1, 1);
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick("gate_wait");
            n++;
            seen = tc;
        end
        check("gate_tc_seen", int'(seen), 1);
        check("gate_period", n + 3, 6);

        // Load beats en while running.
        set_in(1, 4, 1, 0);
        tick("prio_load4");
        set_in(0, 0, 1, 0);
        tick("prio_run");
        tick("prio_run");
        check("prio_at2", int'(counter), 2);
        set_in(1, 6, 1, 0);
        tick("prio_reload");
        check("prio.cnt", int'(counter), 6);
        check("prio.busy", int'(busy), 1);
        check("prio.tc", int'(tc), 0);

        // RUN with en=0 holds.
        set_in(0, 0, 0, 0);
        tick("run_hold");
        check("run_hold.cnt", int'(counter), 6);

        // Zero load finishes immediately with no tc.
        set_in(1, 0, 1, 1);
        tick("zero_load");
        check("zero.done", int'(done), 1);
        check("zero.tc", int'(tc), 0);
        set_in(0, 0, 1, 1);
        tick("zero_park");
        check("zero_park.tc", int'(tc), 0);

        // Full scale one-shot: 7 down to 0, never wraps.
        set_in(1, MAX, 1, 0);
        tick("full_load");
        check("full_load.cnt", int'(counter), MAX);
        set_in(0, 0, 1, 0);
        for (int i = MAX - 1; i >= 0; i--) begin
            tick("full_run");
            check("full_seq", int'(counter), i);
        end
        tick("full_park");
        check("full_park.cnt", int'(counter), 0);
        check("full_park.done", int'(done), 1);

        // Periodic, auto_reload dropped while at zero: DONE, no extra tc.
        set_in(1, 1, 1, 1);
        tick("drop_load");
        set_in(0, 0, 1, 1);
        tick("drop_tc");
        check("drop_tc.tc", int'(tc), 1);
        set_in(0, 0, 1, 0);
        tick("drop_done");
        check("drop_done.done", int'(done), 1);
        check("drop_done.tc", int'(tc), 0);
        check("drop_done.cnt", int'(counter), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            clr = 1'b0;
            set_in(($urandom_range(0, 9) == 0), int'($urandom_range(0, MAX)),
                   ($urandom_range(0, 3) != 0), auto_reload);
            if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
            if ($urandom_range(0, 59) == 0) clr_pulse("rnd_clr");
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
